// File: rtl/mode_report_tx_pkg.sv
// Shared types and constants for the mode report transmitter.
package mode_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT
  } state_e;

  localparam int MSG_LEN = 10;

  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

endpackage

// File: rtl/mode_report_tx_if.sv
// Byte-level handshake between the report generator and the UART transmitter.
interface mode_report_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/mode_report_tx.sv
// Sends "Fx Cx Sx\r\n" over the UART once the mode selects have settled,
// or on request, so the terminal always echoes the mode in effect.
module mode_report_tx
  import mode_report_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 1_000_000,
  parameter int TX_TIMEOUT     = 200_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        sel_final,
  input  logic [1:0]        vga_sw_final,
  input  logic [3:0]        sticker_sel,
  input  logic              force_report,
  mode_report_tx_if.master  tx,
  output logic              report_busy,
  output logic              tx_error
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);

  logic [9:0] cur;
  assign cur = {sel_final, vga_sw_final, sticker_sel};

  state_e        state_q, state_d;
  logic [9:0]    last_rep_q, last_rep_d;
  logic [9:0]    snap_q, snap_d;
  logic [9:0]    cur_prev_q, cur_prev_d;
  logic          force_req_q, force_req_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          report_busy_q, report_busy_d;
  logic          tx_error_q, tx_error_d;
  logic [7:0]    byte_cur;

  // Byte selected by idx from the snapshot taken at LOAD
  always_comb begin
    byte_cur = CH_LF;
    case (idx_q)
      4'd0:    byte_cur = CH_F;
      4'd1:    byte_cur = hex_ascii(snap_q[9:6]);
      4'd2:    byte_cur = CH_SP;
      4'd3:    byte_cur = CH_C;
      4'd4:    byte_cur = 8'h30 + {6'h00, snap_q[5:4]};
      4'd5:    byte_cur = CH_SP;
      4'd6:    byte_cur = CH_S;
      4'd7:    byte_cur = hex_ascii(snap_q[3:0]);
      4'd8:    byte_cur = CH_CR;
      default: byte_cur = CH_LF;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    last_rep_d  = last_rep_q;
    snap_d      = snap_q;
    cur_prev_d  = cur;
    // A force arriving at any time (even on the LOAD cycle) is never lost
    force_req_d = force_req_q | force_report;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    idx_d       = idx_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cur != last_rep_q || force_req_q) begin
          hold_cnt_d = '0;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cur != cur_prev_q)
          hold_cnt_d = '0;
        else if (hold_cnt_q == HW'(HOLDOFF_CYCLES - 1))
          state_d = ST_LOAD;
        else
          hold_cnt_d = hold_cnt_q + 1'b1;
      end
      ST_LOAD: begin
        snap_d      = cur;
        idx_d       = '0;
        force_req_d = force_report;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (!tx.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_cur;
          to_cnt_d   = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx.tx_done) begin
          if (idx_q == 4'(MSG_LEN - 1)) begin
            last_rep_d = snap_q;
            state_d    = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SEND;
          end
        end else if (to_cnt_q == TW'(TX_TIMEOUT - 1)) begin
          // Abandon the line; IDLE retries since last_rep is untouched
          tx_error_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    report_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_rep_q    <= '0;
      snap_q        <= '0;
      cur_prev_q    <= '0;
      force_req_q   <= 1'b0;
      hold_cnt_q    <= '0;
      to_cnt_q      <= '0;
      idx_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      report_busy_q <= 1'b0;
      tx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_rep_q    <= last_rep_d;
      snap_q        <= snap_d;
      cur_prev_q    <= cur_prev_d;
      force_req_q   <= force_req_d;
      hold_cnt_q    <= hold_cnt_d;
      to_cnt_q      <= to_cnt_d;
      idx_q         <= idx_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      report_busy_q <= report_busy_d;
      tx_error_q    <= tx_error_d;
    end
  end

  assign tx.tx_start  = tx_start_q;
  assign tx.tx_data   = tx_data_q;
  assign report_busy  = report_busy_q;
  assign tx_error     = tx_error_q;

endmodule

// File: tb/tb_mode_report_tx.sv
// Directed bench for mode_report_tx with a simple UART transmitter model.
module tb_mode_report_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel = '0;
  logic [1:0] sw  = '0;
  logic [3:0] stk = '0;
  logic       force_report = 1'b0;
  logic       report_busy, tx_error;

  mode_report_tx_if u_if();

  mode_report_tx #(.HOLDOFF_CYCLES(16), .TX_TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (rst),
    .sel_final    (sel),
    .vga_sw_final (sw),
    .sticker_sel  (stk),
    .force_report (force_report),
    .tx           (u_if.master),
    .report_busy  (report_busy),
    .tx_error     (tx_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] cap[$];
  int  start_cnt = 0;
  int  err_cnt   = 0;
  int  viol      = 0;
  bit  done_en   = 1'b1;
  bit  m_active  = 1'b0;
  int  m_cnt     = 0;
  bit  prev_start = 1'b0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transmitter model + protocol monitor: busy one cycle after start, done 20 later
  always @(negedge clk) begin
    if (rst) begin
      u_if.tx_busy = 1'b0;
      u_if.tx_done = 1'b0;
      m_active     = 1'b0;
      m_cnt        = 0;
      prev_start   = 1'b0;
    end else begin
      if (u_if.tx_start) begin
        start_cnt++;
        if (u_if.tx_busy || prev_start) viol++;
      end
      if (tx_error) err_cnt++;
      prev_start   = u_if.tx_start;
      u_if.tx_done = 1'b0;
      if (m_active) begin
        m_cnt++;
        if (m_cnt == 1) u_if.tx_busy = 1'b1;
        if (m_cnt == 21) begin
          u_if.tx_busy = 1'b0;
          u_if.tx_done = done_en;
          m_active     = 1'b0;
        end
      end
      if (u_if.tx_start) begin
        cap.push_back(u_if.tx_data);
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic get_msg(input string tag, input logic [79:0] exp);
    logic [79:0] m;
    int n;
    m = '0;
    n = 0;
    while (cap.size() < 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cap.size() < 10) chk({tag, "_tmo"}, 80'(cap.size()), 80'd10);
    else begin
      for (int i = 0; i < 10; i++) m = {m[71:0], cap.pop_front()};
      chk(tag, m, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (report_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 80'(report_busy), 80'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    chk("rst_start", 80'(u_if.tx_start), 80'd0);
    chk("rst_data",  80'(u_if.tx_data),  80'd0);
    chk("rst_busy",  80'(report_busy),   80'd0);
    chk("rst_err",   80'(tx_error),      80'd0);
    chk("rst_last",  80'(dut.last_rep_q), 80'd0);
    rst = 1'b0;
    cap.delete();
  endtask

  initial begin
    int lat, k;

    // Reset state, then quiet with inputs equal to last_rep
    do_reset();
    cycles(40);
    chk("idle_quiet", 80'(cap.size()), 80'd0);

    // 1: simple report
    sel = 4'd2; sw = 2'd1; stk = 4'd9;
    get_msg("t1_msg", {"F2 C1 S9", 8'h0d, 8'h0a});
    wait_idle("t1");
    chk("t1_last", 80'(dut.last_rep_q), 80'h099);
    cycles(100);
    chk("t1_quiet", 80'(cap.size()), 80'd0);

    // 2: bouncing input restarts holdoff; latency measured from last change
    sel = 4'd3; cycles(10);
    sel = 4'd4; cycles(10);
    sel = 4'd3; cycles(10);
    sel = 4'd5;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (u_if.tx_start) begin lat = n; break; end
    end
    chk("t2_lat", 80'(lat), 80'd19);
    get_msg("t2_msg", {"F5 C1 S9", 8'h0d, 8'h0a});
    wait_idle("t2");
    cycles(60);
    chk("t2_single", 80'(cap.size()), 80'd0);

    // 3: change during send -> old line completes, new line follows
    @(negedge clk);
    sel = 4'd6;
    k = 0;
    while (cap.size() < 3 && k < 2000) begin @(negedge clk); k++; end
    stk = 4'd4;
    get_msg("t3_first",  {"F6 C1 S9", 8'h0d, 8'h0a});
    get_msg("t3_second", {"F6 C1 S4", 8'h0d, 8'h0a});
    wait_idle("t3");
    cycles(60);
    chk("t3_quiet", 80'(cap.size()), 80'd0);

    // 4: force with inputs at reset values
    sel = '0; sw = '0; stk = '0;
    do_reset();
    cycles(40);
    chk("t4_quiet_pre", 80'(cap.size()), 80'd0);
    force_report = 1'b1;
    @(negedge clk);
    force_report = 1'b0;
    get_msg("t4_msg", {"F0 C0 S0", 8'h0d, 8'h0a});
    wait_idle("t4");
    cycles(60);
    chk("t4_quiet_post", 80'(cap.size()), 80'd0);

    // 5: no tx_done -> timeout, then automatic retry from 'F'
    done_en = 1'b0;
    sel = 4'd7;
    k = 0;
    while (!u_if.tx_start && k < 500) begin @(negedge clk); k++; end
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (tx_error) begin lat = n; break; end
    end
    chk("t5_err_lat", 80'(lat), 80'd64);
    chk("t5_busy_low", 80'(report_busy), 80'd0);
    done_en = 1'b1;
    chk("t5_first_byte", 80'(cap.size() > 0 ? cap[0] : 8'h00), 80'h46);
    cap.delete();
    get_msg("t5_retry", {"F7 C0 S0", 8'h0d, 8'h0a});
    wait_idle("t5");
    chk("t5_err_cnt", 80'(err_cnt), 80'd1);

    // 6: reset in the middle of byte 5
    @(negedge clk);
    sel = 4'd1;
    k = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (u_if.tx_start) k++;
      if (k == 5) break;
    end
    chk("t6_reached", 80'(k), 80'd5);
    rst = 1'b1;
    sel = '0;
    #1;
    chk("t6_start_async", 80'(u_if.tx_start), 80'd0);
    chk("t6_busy_async",  80'(report_busy),   80'd0);
    cycles(2);
    rst = 1'b0;
    cap.delete();
    k = start_cnt;
    cycles(80);
    chk("t6_quiet", 80'(start_cnt - k), 80'd0);
    chk("t6_last", 80'(dut.last_rep_q), 80'd0);

    chk("protocol", 80'(viol), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
